// File: rtl/fmc_dvidp_cfg_pkg.sv
// ============================================================================
//  Module   : fmc_dvidp_cfg_pkg
//  Brief    : Shared constants and state encoding for the FMC DVI/DP config sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fmc_dvidp_cfg_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_POR      = 3'd0;
   localparam logic [STATE_W-1:0] ST_FETCH    = 3'd1;
   localparam logic [STATE_W-1:0] ST_FWAIT    = 3'd2;
   localparam logic [STATE_W-1:0] ST_ISSUE    = 3'd3;
   localparam logic [STATE_W-1:0] ST_WAIT_RSP = 3'd4;
   localparam logic [STATE_W-1:0] ST_DONE     = 3'd5;
   localparam logic [STATE_W-1:0] ST_ERROR    = 3'd6;

   typedef enum logic [STATE_W-1:0] {
      S_POR      = ST_POR,
      S_FETCH    = ST_FETCH,
      S_FWAIT    = ST_FWAIT,
      S_ISSUE    = ST_ISSUE,
      S_WAIT_RSP = ST_WAIT_RSP,
      S_DONE     = ST_DONE,
      S_ERROR    = ST_ERROR
   } state_t;

   // Table entry layout: {dev[22:16], reg[15:8], data[7:0]}
   localparam int DEV_MSB = 22;
   localparam int DEV_LSB = 16;
   localparam int REG_LSB = 8;

   localparam logic [6:0] END_DEV = 7'h7F;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Never returns a zero width, so degenerate parameters still elaborate.
   function automatic int clog2_min1(input int v);
      return max2(1, $clog2(v));
   endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_timer.sv
// ============================================================================
//  Module   : cfg_timer
//  Brief    : Loadable down-counter that stops at zero and flags it.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cfg_timer #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= RST_VAL;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - ONE;
      end
   end

   assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/fmc_dvidp_cfg_seq.sv
// ============================================================================
//  Module   : fmc_dvidp_cfg_seq
//  Brief    : Power-on I2C register-table sequencer with per-entry retry.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fmc_dvidp_cfg_seq
   import fmc_dvidp_cfg_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int TBL_AW    = 5,
   parameter int POR_DLY   = 200,
   parameter int RSP_TMO   = 1024,
   parameter int RETRY_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [22:0]       tbl_data,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [6:0]        cmd_dev,
   output logic [7:0]        cmd_reg,
   output logic [7:0]        cmd_data,
   input  logic              rsp_valid,
   input  logic              rsp_nack,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  count
);

   localparam int TMR_W = clog2_min1(max2(POR_DLY, RSP_TMO));
   localparam int RTY_W = clog2_min1(RETRY_MAX + 1);

   localparam logic [TMR_W-1:0]  POR_LOAD = TMR_W'(POR_DLY - 1);
   localparam logic [TMR_W-1:0]  TMO_LOAD = TMR_W'(RSP_TMO - 1);
   localparam logic [RTY_W-1:0]  RTY_LIM  = RTY_W'(RETRY_MAX);
   localparam logic [RTY_W-1:0]  RTY_ONE  = RTY_W'(1);
   localparam logic [TBL_AW-1:0] IDX_LAST = '1;
   localparam logic [TBL_AW-1:0] IDX_ONE  = TBL_AW'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_t            r_state;
   logic [TBL_AW-1:0] r_index;
   logic [RTY_W-1:0]  r_retries;
   logic [CNT_W-1:0]  r_count;
   logic              r_cmd_valid;
   logic [6:0]        r_cmd_dev;
   logic [7:0]        r_cmd_reg;
   logic [7:0]        r_cmd_data;
   logic              r_busy;
   logic              r_done;
   logic              r_error;

   logic              w_tmr_load;
   logic [TMR_W-1:0]  w_tmr_val;
   logic              w_tmr_zero;
   logic              w_ack;
   logic              w_fail;

   // One timer serves both the power-on delay and the response timeout.
   cfg_timer #(
      .WIDTH   (TMR_W),
      .RST_VAL (POR_LOAD)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .zero     (w_tmr_zero)
   );

   assign w_ack  = rsp_valid && !rsp_nack;
   assign w_fail = (rsp_valid && rsp_nack) || (!rsp_valid && w_tmr_zero);

   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = TMO_LOAD;
      case (r_state)
         S_ISSUE: begin
            if (r_cmd_valid && cmd_ready) begin
               w_tmr_load = 1'b1;
            end
         end
         S_DONE, S_ERROR: begin
            if (start) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = POR_LOAD;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_POR;
         r_index     <= '0;
         r_retries   <= '0;
         r_count     <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_dev   <= '0;
         r_cmd_reg   <= '0;
         r_cmd_data  <= '0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         case (r_state)
            S_POR: begin
               if (w_tmr_zero) begin
                  r_state <= S_FETCH;
                  r_index <= '0;
               end
            end
            S_FETCH: begin
               r_state <= S_FWAIT;
            end
            S_FWAIT: begin
               r_cmd_dev  <= tbl_data[DEV_MSB:DEV_LSB];
               r_cmd_reg  <= tbl_data[DEV_LSB-1:REG_LSB];
               r_cmd_data <= tbl_data[REG_LSB-1:0];
               if (tbl_data[DEV_MSB:DEV_LSB] == END_DEV) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state     <= S_ISSUE;
                  r_cmd_valid <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= S_WAIT_RSP;
               end
            end
            S_WAIT_RSP: begin
               if (w_ack) begin
                  if (r_count != CNT_MAX) begin
                     r_count <= r_count + CNT_ONE;
                  end
                  r_retries <= '0;
                  if (r_index == IDX_LAST) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_index <= r_index + IDX_ONE;
                     r_state <= S_FETCH;
                  end
               end else if (w_fail) begin
                  // Retry reuses the captured command registers unchanged.
                  if (r_retries < RTY_LIM) begin
                     r_retries   <= r_retries + RTY_ONE;
                     r_cmd_valid <= 1'b1;
                     r_state     <= S_ISSUE;
                  end else begin
                     r_state <= S_ERROR;
                     r_busy  <= 1'b0;
                     r_error <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERROR: begin
               if (start) begin
                  r_state   <= S_POR;
                  r_done    <= 1'b0;
                  r_error   <= 1'b0;
                  r_count   <= '0;
                  r_index   <= '0;
                  r_retries <= '0;
                  r_busy    <= 1'b1;
               end
            end
            default: begin
               r_state <= S_POR;
            end
         endcase
      end
   end

   assign tbl_addr  = r_index;
   assign cmd_valid = r_cmd_valid;
   assign cmd_dev   = r_cmd_dev;
   assign cmd_reg   = r_cmd_reg;
   assign cmd_data  = r_cmd_data;
   assign busy      = r_busy;
   assign done      = r_done;
   assign error     = r_error;
   assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fmc_dvidp_cfg_seq.sv
// ============================================================================
//  Module   : tb_fmc_dvidp_cfg_seq
//  Brief    : Directed-vector bench for the FMC DVI/DP config sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fmc_dvidp_cfg_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: 8-bit count, 3 retries; instance B: 2-bit count, 1 retry.
   logic        a_reset, a_start, a_cmd_ready, a_rsp_valid, a_rsp_nack;
   logic [4:0]  a_tbl_addr;
   logic [22:0] a_tbl_data = '0;
   logic        a_cmd_valid, a_busy, a_done, a_error;
   logic [6:0]  a_cmd_dev;
   logic [7:0]  a_cmd_reg, a_cmd_data, a_count;
   logic [22:0] rom_a [32];

   logic        b_reset, b_start, b_cmd_ready, b_rsp_valid, b_rsp_nack;
   logic [4:0]  b_tbl_addr;
   logic [22:0] b_tbl_data = '0;
   logic        b_cmd_valid, b_busy, b_done, b_error;
   logic [6:0]  b_cmd_dev;
   logic [7:0]  b_cmd_reg, b_cmd_data;
   logic [1:0]  b_count;
   logic [22:0] rom_b [32];

   always @(posedge clk) a_tbl_data <= rom_a[a_tbl_addr];
   always @(posedge clk) b_tbl_data <= rom_b[b_tbl_addr];

   fmc_dvidp_cfg_seq #(
      .CNT_W(8), .TBL_AW(5), .POR_DLY(200), .RSP_TMO(16), .RETRY_MAX(3)
   ) dut_a (
      .clk(clk), .reset(a_reset), .start(a_start),
      .tbl_addr(a_tbl_addr), .tbl_data(a_tbl_data),
      .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_dev(a_cmd_dev), .cmd_reg(a_cmd_reg), .cmd_data(a_cmd_data),
      .rsp_valid(a_rsp_valid), .rsp_nack(a_rsp_nack),
      .busy(a_busy), .done(a_done), .error(a_error), .count(a_count)
   );

   fmc_dvidp_cfg_seq #(
      .CNT_W(2), .TBL_AW(5), .POR_DLY(20), .RSP_TMO(16), .RETRY_MAX(1)
   ) dut_b (
      .clk(clk), .reset(b_reset), .start(b_start),
      .tbl_addr(b_tbl_addr), .tbl_data(b_tbl_data),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_dev(b_cmd_dev), .cmd_reg(b_cmd_reg), .cmd_data(b_cmd_data),
      .rsp_valid(b_rsp_valid), .rsp_nack(b_rsp_nack),
      .busy(b_busy), .done(b_done), .error(b_error), .count(b_count)
   );

   typedef struct {
      logic [22:0] ent;
      logic [4:0]  addr;
      bit          nack;
      int          rdy_lo;
      logic [7:0]  cnt;
   } vec_t;

   vec_t        vecs [13];
   logic [22:0] ent [5];
   logic [22:0] endm;
   int          n_vec = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic wait_valid(input bit use_b, output int n);
      n = 0;
      while (!(use_b ? b_cmd_valid : a_cmd_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(use_b ? "b_valid_seen" : "a_valid_seen", n, use_b ? b_cmd_valid : a_cmd_valid, 1);
   endtask

   task automatic serve_a(input int i);
      vec_t v;
      int   n;
      v = vecs[i];
      wait_valid(1'b0, n);
      chk("a_addr", i, a_tbl_addr, v.addr);
      chk("a_cmd", i, {a_cmd_dev, a_cmd_reg, a_cmd_data}, v.ent);
      for (int k = 1; k < v.rdy_lo; k++) begin
         @(negedge clk);
         chk("a_hold", i, {a_cmd_valid, a_cmd_dev, a_cmd_reg, a_cmd_data}, {1'b1, v.ent});
      end
      a_cmd_ready = 1'b1;
      @(negedge clk);
      a_cmd_ready = 1'b0;
      chk("a_xfer_once", i, a_cmd_valid, 0);
      repeat (9) @(negedge clk);
      a_rsp_valid = 1'b1;
      a_rsp_nack  = v.nack;
      @(negedge clk);
      a_rsp_valid = 1'b0;
      a_rsp_nack  = 1'b0;
      chk("a_count", i, a_count, v.cnt);
   endtask

   task automatic serve_b(input int i);
      vec_t v;
      int   n;
      v = vecs[i];
      wait_valid(1'b1, n);
      chk("b_addr", i, b_tbl_addr, v.addr);
      chk("b_cmd", i, {b_cmd_dev, b_cmd_reg, b_cmd_data}, v.ent);
      @(negedge clk);
      b_rsp_valid = 1'b1;
      @(negedge clk);
      b_rsp_valid = 1'b0;
      chk("b_count", i, b_count, v.cnt[1:0]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, nv, v1, v2, er;

      ent[0] = {7'h39, 8'h08, 8'hB5};
      ent[1] = {7'h48, 8'h41, 8'h1C};
      ent[2] = {7'h60, 8'h0A, 8'h03};
      ent[3] = {7'h39, 8'h0C, 8'h7E};
      ent[4] = {7'h48, 8'h02, 8'h55};
      endm   = {7'h7F, 8'h00, 8'h00};

      vecs[0]  = '{ent[0], 5'd0, 1'b0, 0,  8'd1};
      vecs[1]  = '{ent[1], 5'd1, 1'b0, 0,  8'd2};
      vecs[2]  = '{ent[2], 5'd2, 1'b0, 0,  8'd3};
      vecs[3]  = '{ent[0], 5'd0, 1'b0, 0,  8'd1};
      vecs[4]  = '{ent[1], 5'd1, 1'b1, 0,  8'd1};
      vecs[5]  = '{ent[1], 5'd1, 1'b1, 0,  8'd1};
      vecs[6]  = '{ent[1], 5'd1, 1'b0, 0,  8'd2};
      vecs[7]  = '{ent[2], 5'd2, 1'b0, 50, 8'd3};
      vecs[8]  = '{ent[0], 5'd0, 1'b0, 0,  8'd1};
      vecs[9]  = '{ent[1], 5'd1, 1'b0, 0,  8'd2};
      vecs[10] = '{ent[2], 5'd2, 1'b0, 0,  8'd3};
      vecs[11] = '{ent[3], 5'd3, 1'b0, 0,  8'd3};
      vecs[12] = '{ent[4], 5'd4, 1'b0, 0,  8'd3};

      for (int k = 0; k < 32; k++) begin
         rom_a[k] = endm;
         rom_b[k] = endm;
      end
      for (int k = 0; k < 3; k++) rom_a[k] = ent[k];

      a_reset = 1'b1; a_start = 1'b0; a_cmd_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_nack = 1'b0;
      b_reset = 1'b1; b_start = 1'b0; b_cmd_ready = 1'b1; b_rsp_valid = 1'b0; b_rsp_nack = 1'b0;
      repeat (3) @(negedge clk);

      chk("a_rst_flags", 0, {a_busy, a_done, a_error, a_cmd_valid}, 4'b1000);
      chk("a_rst_count", 0, a_count, 0);
      chk("a_rst_addr", 0, a_tbl_addr, 0);
      chk("a_rst_cmd", 0, {a_cmd_dev, a_cmd_reg, a_cmd_data}, 0);

      // Three-entry table, every write ACKed after 10 cycles.
      a_reset = 1'b0;
      wait_valid(1'b0, n);
      chk("a_por_latency", 0, n, 202);
      for (int i = 0; i < 3; i++) serve_a(i);
      repeat (2) @(negedge clk);
      chk("a_run1_flags", 0, {a_busy, a_done, a_error}, 3'b010);
      chk("a_run1_count", 0, a_count, 3);

      // Restart from DONE; a second start and a stray response during POR are ignored.
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      chk("a_start_flags", 0, {a_busy, a_done, a_error}, 3'b100);
      chk("a_start_count", 0, a_count, 0);
      repeat (49) @(negedge clk);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      repeat (9) @(negedge clk);
      a_rsp_valid = 1'b1;
      @(negedge clk);
      a_rsp_valid = 1'b0;
      wait_valid(1'b0, n);
      chk("a_restart_latency", 0, 61 + n, 203);
      for (int i = 3; i < 8; i++) serve_a(i);
      repeat (2) @(negedge clk);
      chk("a_run2_flags", 0, {a_busy, a_done, a_error}, 3'b010);
      chk("a_run2_count", 0, a_count, 3);

      // Reset while waiting for a response.
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      serve_a(3);
      wait_valid(1'b0, n);
      a_cmd_ready = 1'b1;
      @(negedge clk);
      a_cmd_ready = 1'b0;
      chk("a_in_wait", 0, {a_cmd_valid, a_tbl_addr}, {1'b0, 5'd1});
      a_reset = 1'b1;
      @(negedge clk);
      chk("a_rstw_flags", 0, {a_busy, a_done, a_error, a_cmd_valid}, 4'b1000);
      chk("a_rstw_count", 0, a_count, 0);
      chk("a_rstw_addr", 0, a_tbl_addr, 0);

      // Reset while a command is pending with ready low.
      a_reset = 1'b0;
      wait_valid(1'b0, n);
      repeat (3) @(negedge clk);
      a_reset = 1'b1;
      @(negedge clk);
      chk("a_rsti_valid", 0, {a_busy, a_cmd_valid}, 2'b10);

      // Empty table on B: done exactly POR_DLY+2 cycles after reset release.
      b_reset = 1'b0;
      n = 0;
      while (!b_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b_empty_latency", 0, n, 22);
      chk("b_empty_flags", 0, {b_busy, b_done, b_error, b_count}, 5'b01000);

      // Entry 0 never answered: two issues, each followed by a 16-cycle timeout.
      b_reset = 1'b1;
      rom_b[0] = ent[0];
      repeat (2) @(negedge clk);
      b_reset = 1'b0;
      nv = 0; v1 = -1; v2 = -1; er = -1;
      for (int c = 1; c <= 120; c++) begin
         @(negedge clk);
         if (b_cmd_valid) begin
            nv++;
            if (nv == 1) v1 = c;
            else if (nv == 2) v2 = c;
         end
         if (b_error && er < 0) er = c;
      end
      chk("b_tmo_issues", 0, nv, 2);
      chk("b_tmo_first", 0, v1, 22);
      chk("b_tmo_second", 0, v2, 39);
      chk("b_tmo_error_at", 0, er, 56);
      chk("b_tmo_flags", 0, {b_busy, b_done, b_error, b_count}, 5'b00100);
      chk("b_tmo_addr", 0, b_tbl_addr, 0);
      chk("b_tmo_cmd", 0, {b_cmd_dev, b_cmd_reg, b_cmd_data}, ent[0]);

      // Five ACKed entries into a 2-bit counter.
      b_reset = 1'b1;
      for (int k = 0; k < 5; k++) rom_b[k] = ent[k];
      rom_b[5] = endm;
      repeat (2) @(negedge clk);
      b_reset = 1'b0;
      for (int i = 8; i < 13; i++) serve_b(i);
      repeat (2) @(negedge clk);
      chk("b_sat_flags", 0, {b_busy, b_done, b_error}, 3'b010);
      chk("b_sat_count", 0, b_count, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
